microsequencer: RTL and testbench
=================================

# microsequencer

Next-address sequencer for the microprogrammed control unit. Each cycle it selects the next control-store address from the microinstruction currently held in the control register: N, inv, select and cr, plus curr_state. It also takes instruction-decode and status/memory-completion inputs. Around that selection it keeps a microsubroutine return stack, a memory-wait timeout counter and a run/fault state machine. Its address output drives the control-store ROM, whose word the control register latches on the next clock edge.

## Interface
Parameters:
- ADDR_W, 10, control-store address width
- RESET_STATE, 10'd0, first address issued after reset
- FETCH_STATE, 10'd1, target of N=1
- FAULT_STATE, 10'd1023, address held while faulted
- STACK_DEPTH, 4, return-stack entries (power of two)
- MOC_TIMEOUT, 15, max consecutive wait cycles on N=7

Ports:
- clk, in, 1, system clock, all state on rising edge
- reset_n, in, 1, synchronous active-low reset
- N, in, 3, next-address type from the control register
- inv, in, 1, invert the selected condition
- select, in, 2, condition select
- cr, in, ADDR_W, branch/call target field
- curr_state, in, ADDR_W, address of the microinstruction now in the control register
- decode_state, in, ADDR_W, entry address from the instruction decoder
- cond, in, 4, status conditions {C,V,N,Z} at indices 3..0
- moc, in, 1, memory operation complete
- next_state, out, ADDR_W, control-store address (combinational from registered state)
- fault, out, 1, sticky fault flag (registered)
- fault_code, out, 2, 0 none, 1 stack overflow, 2 stack underflow, 3 MOC timeout

## Operation
- FSM states are RESET, RUN and FAULT.
- Reset is synchronous. While reset_n=0, FSM=RESET, sp=0, the wait counter is 0, fault=0 and fault_code=0.
- next_state=RESET_STATE in RESET. Reset has priority over every other input and aborts any pending wait or stack operation.
- RESET -> RUN on the first edge with reset_n=1. That cycle issues RESET_STATE, so the instruction at RESET_STATE is loaded one edge later.
- In RUN, with c = cond[select] ^ inv and inc = curr_state+1 (wraps 1023 -> 0):
  - N=0 -> decode_state
  - N=1 -> FETCH_STATE
  - N=2 -> c ? cr : inc
  - N=3 -> inc
  - N=4 -> cr
  - N=5 (call) -> push inc, go to cr
  - N=6 (return) -> pop, go to the top-of-stack entry
  - N=7 (wait) -> moc ? inc : curr_state
- Wait counter:
  - Increments each RUN cycle with N=7 and moc=0.
  - Clears on any other cycle.
  - Reaching MOC_TIMEOUT -> FAULT with code 3. That cycle issues FAULT_STATE.
- Stack errors:
  - Push with sp=STACK_DEPTH -> FAULT, code 1. No write occurs.
  - Pop with sp=0 -> FAULT, code 2.
- In FAULT, next_state=FAULT_STATE and fault=1. Only reset_n=0 leaves FAULT.
- The first fault wins. fault_code never changes while faulted.

## Timing
- Address selection is combinational: next_state is valid in the same cycle as the control-register fields.
- Stack, sp, wait counter, FSM and fault update on the rising edge.
- A push and a call target issued in cycle t are visible to a return issued in cycle t+1 or later.
- The fault transition takes effect at the edge of the offending cycle, and fault asserts after that edge.
- moc=1 on the cycle the counter would reach MOC_TIMEOUT takes precedence, with no fault.

## Configuration
- MICROSEQ_STACK_EN defined: N=5 and N=6 behave as above, and codes 1 and 2 are possible.
- MICROSEQ_STACK_EN undefined: no stack storage. N=5 behaves as N=4 (jump cr), N=6 behaves as N=1 (FETCH_STATE), and fault_code is only ever 0 or 3.

## Structure
- Package microseq_pkg holds the N encodings (NA_DECODE, NA_FETCH, NA_CBRANCH, NA_INC, NA_JUMP, NA_CALL, NA_RET, NA_WAIT), the FSM state enum and the fault-code constants.
- One sub-module, microseq_stack: a LIFO with push, pop, full, empty and top outputs, instantiated only under MICROSEQ_STACK_EN.

## Test plan
- Reset and first fetch:
  - Stimulus: hold reset_n=0 for 3 cycles, then release.
  - Response: next_state=0 during reset and the release cycle; fault=0.
- Conditional branch:
  - Stimulus: curr_state=20, N=2, select=0, cond=4'b0001, inv=0, cr=100.
  - Response: next_state=100. With inv=1: next_state=21.
- Call and return:
  - Stimulus: N=5 at curr_state=50 with cr=200; later N=6 at curr_state=210.
  - Response: next_state=200, then 51.
  - Stimulus: 5 nested calls.
  - Response: fault=1, fault_code=1, next_state=1023.
- Memory wait:
  - Stimulus: N=7 at curr_state=30 with moc=0 for 5 cycles, then moc=1.
  - Response: next_state=30 for 5 cycles, then 31.
  - Stimulus: moc held 0.
  - Response: after 15 wait cycles fault_code=3.
- Wrap and decode:
  - Stimulus: N=3 at curr_state=1023.
  - Response: next_state=0.
  - Stimulus: N=0 with decode_state=300.
  - Response: next_state=300.
- Reset mid-fault and mid-wait:
  - Stimulus: assert reset_n=0 while faulted or waiting.
  - Response: next_state=0, fault=0, sp=0 on the next edge.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-address types, FSM states, fault codes.
package microseq_pkg;

    localparam logic [2:0] NA_DECODE  = 3'd0;
    localparam logic [2:0] NA_FETCH   = 3'd1;
    localparam logic [2:0] NA_CBRANCH = 3'd2;
    localparam logic [2:0] NA_INC     = 3'd3;
    localparam logic [2:0] NA_JUMP    = 3'd4;
    localparam logic [2:0] NA_CALL    = 3'd5;
    localparam logic [2:0] NA_RET     = 3'd6;
    localparam logic [2:0] NA_WAIT    = 3'd7;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_TIMEOUT   = 2'd3;

endpackage

// File: rtl/microseq_stack.sv
// Microsubroutine return-address LIFO. DEPTH must be a power of two, at least 2.
module microseq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   sp;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign wr_ptr = sp[AW-1:0];
    assign rd_ptr = wr_ptr - AW'(1);
    assign full   = (sp == (AW+1)'(DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (AW+1)'(1);
        end
    end

    // Storage needs no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && push && !full) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Next-address sequencer for the microprogrammed control unit.
// Define MICROSEQ_STACK_EN to enable the call/return stack (N=5/N=6).
module microsequencer
    import microseq_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] RESET_STATE = 10'd0,
    parameter logic [ADDR_W-1:0] FETCH_STATE = 10'd1,
    parameter logic [ADDR_W-1:0] FAULT_STATE = 10'd1023,
    parameter int                STACK_DEPTH = 4,
    parameter int                MOC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        N,
    input  logic              inv,
    input  logic [1:0]        select,
    input  logic [ADDR_W-1:0] cr,
    input  logic [ADDR_W-1:0] curr_state,
    input  logic [ADDR_W-1:0] decode_state,
    input  logic [3:0]        cond,
    input  logic              moc,
    output logic [ADDR_W-1:0] next_state,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int                CW  = $clog2(MOC_TIMEOUT + 1);
    localparam logic [CW-1:0]     TMO = CW'(MOC_TIMEOUT);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    seq_state_e        state, state_nx;
    logic [CW-1:0]     wcnt, wcnt_nx, wcnt_inc;
    logic [ADDR_W-1:0] inc;
    logic [1:0]        err;
    logic              c;

    assign inc      = curr_state + ONE;
    assign wcnt_inc = wcnt + CW'(1);
    assign c        = cond[select] ^ inv;

`ifdef MICROSEQ_STACK_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    microseq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (inc),
        .top     (stk_top),
        .full    (stk_full),
        .empty   (stk_empty)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_RESET;
            wcnt       <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            // First fault wins: the code is only captured on entry to FAULT.
            if (state == ST_RUN && err != FC_NONE) begin
                fault      <= 1'b1;
                fault_code <= err;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        next_state = RESET_STATE;
        wcnt_nx    = '0;
        err        = FC_NONE;
`ifdef MICROSEQ_STACK_EN
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
`endif
        case (state)
            ST_RESET: begin
                state_nx   = ST_RUN;
                next_state = RESET_STATE;
            end
            ST_RUN: begin
                case (N)
                    NA_DECODE:  next_state = decode_state;
                    NA_FETCH:   next_state = FETCH_STATE;
                    NA_CBRANCH: next_state = c ? cr : inc;
                    NA_INC:     next_state = inc;
                    NA_JUMP:    next_state = cr;
`ifdef MICROSEQ_STACK_EN
                    NA_CALL: begin
                        if (stk_full) begin
                            err = FC_OVERFLOW;
                        end else begin
                            stk_push   = 1'b1;
                            next_state = cr;
                        end
                    end
                    NA_RET: begin
                        if (stk_empty) begin
                            err = FC_UNDERFLOW;
                        end else begin
                            stk_pop    = 1'b1;
                            next_state = stk_top;
                        end
                    end
`else
                    NA_CALL:    next_state = cr;
                    NA_RET:     next_state = FETCH_STATE;
`endif
                    NA_WAIT: begin
                        // moc on the would-be timeout cycle still completes cleanly.
                        if (moc) begin
                            next_state = inc;
                        end else if (wcnt_inc == TMO) begin
                            err = FC_TIMEOUT;
                        end else begin
                            next_state = curr_state;
                            wcnt_nx    = wcnt_inc;
                        end
                    end
                    default: next_state = inc;
                endcase
                if (err != FC_NONE) begin
                    state_nx   = ST_FAULT;
                    next_state = FAULT_STATE;
                    wcnt_nx    = '0;
                end
            end
            ST_FAULT: begin
                next_state = FAULT_STATE;
            end
            default: begin
                state_nx   = ST_RESET;
                next_state = RESET_STATE;
            end
        endcase
        if (!reset_n) begin
            next_state = RESET_STATE;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus randomized run against a queue-based model.
module tb_microsequencer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    N = '0;
    logic          inv = 1'b0;
    logic [1:0]    select = '0;
    logic [AW-1:0] cr = '0, curr_state = '0, decode_state = '0;
    logic [3:0]    cond = '0;
    logic          moc = 1'b0;
    logic [AW-1:0] next_state;
    logic          fault;
    logic [1:0]    fault_code;

    microsequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .N            (N),
        .inv          (inv),
        .select       (select),
        .cr           (cr),
        .curr_state   (curr_state),
        .decode_state (decode_state),
        .cond         (cond),
        .moc          (moc),
        .next_state   (next_state),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=reset, 1=run, 2=fault; the stack is a plain queue.
    int m_mode = 0;
    int m_stk[$];
    int m_wait = 0;
    bit m_fault = 0;
    int m_fc = 0;

    logic [AW-1:0] exp_ns, obs_ns;
    logic          exp_f, obs_f;
    logic [1:0]    exp_fc, obs_fc;

    // Drive one cycle, sample next_state before the edge and fault after it.
    task automatic step(input bit rn, input int n, input int csv, input int crv, input bit mc,
                        input bit iv, input int sl, input int cd, input int dec);
        int inc, err, nx;
        reset_n = rn; N = 3'(n); curr_state = AW'(csv); cr = AW'(crv); moc = mc;
        inv = iv; select = 2'(sl); cond = 4'(cd); decode_state = AW'(dec);
        #1;
        inc = (csv + 1) % 1024;
        err = 0;
        nx  = 0;
        if (!rn || m_mode == 0) nx = 0;
        else if (m_mode == 2) nx = 1023;
        else begin
            case (n)
                0: nx = dec;
                1: nx = 1;
                2: nx = ((((cd >> sl) & 1) ^ int'(iv)) != 0) ? crv : inc;
                3: nx = inc;
                4: nx = crv;
`ifdef MICROSEQ_STACK_EN
                5: if (m_stk.size() == 4) err = 1; else nx = crv;
                6: if (m_stk.size() == 0) err = 2; else nx = m_stk[$];
`else
                5: nx = crv;
                6: nx = 1;
`endif
                default: if (mc) nx = inc; else if (m_wait + 1 >= 15) err = 3; else nx = csv;
            endcase
            if (err != 0) nx = 1023;
        end
        exp_ns = AW'(nx);
        obs_ns = next_state;
        @(posedge clk); #1;
        if (!rn) begin
            m_mode = 0; m_stk.delete(); m_wait = 0; m_fault = 0; m_fc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (err != 0) begin
                m_mode = 2; m_fault = 1; m_fc = err; m_wait = 0;
            end else begin
                m_wait = (n == 7 && !mc) ? m_wait + 1 : 0;
`ifdef MICROSEQ_STACK_EN
                if (n == 5) m_stk.push_back(inc);
                else if (n == 6) void'(m_stk.pop_back());
`endif
            end
        end
        exp_f  = m_fault;
        exp_fc = 2'(m_fc);
        obs_f  = fault;
        obs_fc = fault_code;
    endtask

    task automatic apply_reset();
        step(0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, $urandom_range(0, 7), $urandom_range(0, 1023), 5, 0, 0, 0, 0, 9);
            tests++;
            if (obs_ns !== 10'd0 || obs_f !== 1'b0 || obs_fc !== 2'd0) begin
                fails++;
                $display("FAIL reset_hold got ns=%0d f=%b fc=%0d want ns=0 f=0 fc=0", obs_ns, obs_f, obs_fc);
            end
        end
        step(1, 4, 77, 88, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd0 || obs_f !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got ns=%0d f=%b want ns=0 f=0", obs_ns, obs_f);
        end
    endtask

    task automatic test_cbranch();
        step(1, 2, 20, 100, 0, 0, 0, 4'b0001, 0);
        tests++;
        if (obs_ns !== 10'd100) begin
            fails++; $display("FAIL cbranch_taken got %0d want 100", obs_ns);
        end
        step(1, 2, 20, 100, 0, 1, 0, 4'b0001, 0);
        tests++;
        if (obs_ns !== 10'd21) begin
            fails++; $display("FAIL cbranch_inv got %0d want 21", obs_ns);
        end
        step(1, 2, 20, 100, 0, 0, 3, 4'b0111, 0);
        tests++;
        if (obs_ns !== 10'd21) begin
            fails++; $display("FAIL cbranch_sel3 got %0d want 21", obs_ns);
        end
    endtask

    task automatic test_call_ret();
        step(1, 5, 50, 200, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd200) begin
            fails++; $display("FAIL call_target got %0d want 200", obs_ns);
        end
        step(1, 3, 200, 0, 0, 0, 0, 0, 0);
        step(1, 6, 210, 0, 0, 0, 0, 0, 0);
`ifdef MICROSEQ_STACK_EN
        tests++;
        if (obs_ns !== 10'd51) begin
            fails++; $display("FAIL ret_addr got %0d want 51", obs_ns);
        end
        step(1, 5, 70, 500, 0, 0, 0, 0, 0);
        step(1, 6, 500, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd71) begin
            fails++; $display("FAIL ret_b2b got %0d want 71", obs_ns);
        end
        for (int i = 0; i < 5; i++) step(1, 5, 60 + i, 400 + i, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd1023 || obs_f !== 1'b1 || obs_fc !== 2'd1) begin
            fails++;
            $display("FAIL overflow got ns=%0d f=%b fc=%0d want ns=1023 f=1 fc=1", obs_ns, obs_f, obs_fc);
        end
        apply_reset();
        step(1, 6, 90, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd1023 || obs_f !== 1'b1 || obs_fc !== 2'd2) begin
            fails++;
            $display("FAIL underflow got ns=%0d f=%b fc=%0d want ns=1023 f=1 fc=2", obs_ns, obs_f, obs_fc);
        end
`else
        tests++;
        if (obs_ns !== 10'd1) begin
            fails++; $display("FAIL ret_as_fetch got %0d want 1", obs_ns);
        end
        for (int i = 0; i < 5; i++) step(1, 5, 60 + i, 400 + i, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd404 || obs_f !== 1'b0 || obs_fc !== 2'd0) begin
            fails++;
            $display("FAIL call_as_jump got ns=%0d f=%b fc=%0d want ns=404 f=0 fc=0", obs_ns, obs_f, obs_fc);
        end
`endif
        apply_reset();
    endtask

    task automatic test_wait();
        for (int i = 0; i < 5; i++) begin
            step(1, 7, 30, 0, 0, 0, 0, 0, 0);
            tests++;
            if (obs_ns !== 10'd30) begin
                fails++; $display("FAIL wait_hold cycle %0d got %0d want 30", i, obs_ns);
            end
        end
        step(1, 7, 30, 0, 1, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd31) begin
            fails++; $display("FAIL wait_done got %0d want 31", obs_ns);
        end
        // moc on the 15th cycle wins over the timeout
        for (int i = 0; i < 14; i++) step(1, 7, 30, 0, 0, 0, 0, 0, 0);
        step(1, 7, 30, 0, 1, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd31 || obs_f !== 1'b0) begin
            fails++; $display("FAIL wait_moc_edge got ns=%0d f=%b want ns=31 f=0", obs_ns, obs_f);
        end
        for (int i = 1; i <= 15; i++) begin
            step(1, 7, 30, 0, 0, 0, 0, 0, 0);
            if (i == 14) begin
                tests++;
                if (obs_ns !== 10'd30 || obs_f !== 1'b0) begin
                    fails++; $display("FAIL wait_14 got ns=%0d f=%b want ns=30 f=0", obs_ns, obs_f);
                end
            end
        end
        tests++;
        if (obs_ns !== 10'd1023 || obs_f !== 1'b1 || obs_fc !== 2'd3) begin
            fails++;
            $display("FAIL timeout got ns=%0d f=%b fc=%0d want ns=1023 f=1 fc=3", obs_ns, obs_f, obs_fc);
        end
        step(1, 6, 5, 0, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0, 300);
        tests++;
        if (obs_ns !== 10'd1023 || obs_f !== 1'b1 || obs_fc !== 2'd3) begin
            fails++;
            $display("FAIL fault_sticky got ns=%0d f=%b fc=%0d want ns=1023 f=1 fc=3", obs_ns, obs_f, obs_fc);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 7, 30, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd0 || obs_f !== 1'b0 || obs_fc !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_fault got ns=%0d f=%b fc=%0d want 0/0/0", obs_ns, obs_f, obs_fc);
        end
        step(1, 7, 30, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 7, 40, 0, 0, 0, 0, 0, 0);
        step(0, 7, 40, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd0 || obs_f !== 1'b0) begin
            fails++; $display("FAIL reset_mid_wait got ns=%0d f=%b want ns=0 f=0", obs_ns, obs_f);
        end
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Counter must have restarted: 14 more waits stay clean.
        for (int i = 0; i < 14; i++) step(1, 7, 40, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd40 || obs_f !== 1'b0) begin
            fails++; $display("FAIL wait_cleared got ns=%0d f=%b want ns=40 f=0", obs_ns, obs_f);
        end
        apply_reset();
    endtask

    task automatic test_wrap_decode();
        step(1, 3, 1023, 0, 0, 0, 0, 0, 0);
        tests++;
        if (obs_ns !== 10'd0) begin
            fails++; $display("FAIL wrap got %0d want 0", obs_ns);
        end
        step(1, 0, 12, 0, 0, 0, 0, 0, 300);
        tests++;
        if (obs_ns !== 10'd300) begin
            fails++; $display("FAIL decode got %0d want 300", obs_ns);
        end
        step(1, 1, 12, 0, 0, 0, 0, 0, 300);
        tests++;
        if (obs_ns !== 10'd1) begin
            fails++; $display("FAIL fetch got %0d want 1", obs_ns);
        end
        step(1, 4, 12, 777, 0, 0, 0, 0, 300);
        tests++;
        if (obs_ns !== 10'd777) begin
            fails++; $display("FAIL jump got %0d want 777", obs_ns);
        end
    endtask

    task automatic test_random();
        int n, last_n;
        bit rn;
        last_n = 3;
        for (int i = 0; i < 600; i++) begin
            rn = !(($urandom_range(0, 59) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0));
            n = $urandom_range(0, 7);
            if (last_n == 7 && $urandom_range(0, 9) != 0) n = 7;
            last_n = n;
            step(rn, n, ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 1023),
                 $urandom_range(0, 1023), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1023));
            tests++;
            if (obs_ns !== exp_ns || obs_f !== exp_f || obs_fc !== exp_fc) begin
                fails++;
                $display("FAIL random[%0d] N=%0d got ns=%0d f=%b fc=%0d want ns=%0d f=%b fc=%0d",
                         i, n, obs_ns, obs_f, obs_fc, exp_ns, exp_f, exp_fc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cbranch();
        test_call_ret();
        test_wait();
        test_reset_mid();
        test_wrap_decode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
